// File: rtl/jk_bank_arbiter.sv
// Round-robin sequencer that shares one bank of JK flip-flops between NREQ requesters.
// Define JK_ARB_FIXED_PRIORITY_EN to replace round-robin with fixed lowest-index-wins priority.
module jk_bank_arbiter #(
  parameter int unsigned NREQ  = 4,
  parameter int unsigned WIDTH = 8,
  parameter int unsigned IDXW  = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NREQ-1:0]        req,
  input  logic [2*NREQ-1:0]      cmd,
  input  logic [NREQ*IDXW-1:0]   idx,
  output logic [NREQ-1:0]        gnt,
  output logic [NREQ-1:0]        ack,
  output logic                   busy,
  output logic [WIDTH-1:0]       q,
  output logic                   bad_idx
);

  localparam int unsigned IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_GRANT = 2'd1,
    S_APPLY = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [IDW-1:0]    win_q, win_d;
  logic [1:0]        cmd_q, cmd_d;
  logic [IDXW-1:0]   idx_q, idx_d;
  logic [NREQ-1:0]   gnt_q, gnt_d;
  logic [NREQ-1:0]   ack_q, ack_d;
  logic              busy_q, busy_d;
  logic              bad_q, bad_d;
  logic [WIDTH-1:0]  q_q, q_d;
  logic [IDW-1:0]    start_c;
  logic              found_c;
  logic [IDW-1:0]    pick_c;

`ifdef JK_ARB_FIXED_PRIORITY_EN
  assign start_c = '0;
`else
  logic [IDW-1:0]    ptr_q, ptr_d;
  assign start_c = ptr_q;
`endif

  // First active requester at or after start_c, wrapping at NREQ.
  always_comb begin
    found_c = 1'b0;
    pick_c  = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      int unsigned j;
      j = 32'(start_c) + k;
      if (j >= NREQ) j = j - NREQ;
      if (!found_c && req[IDW'(j)]) begin
        found_c = 1'b1;
        pick_c  = IDW'(j);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    win_d   = win_q;
    cmd_d   = cmd_q;
    idx_d   = idx_q;
    gnt_d   = gnt_q;
    ack_d   = '0;
    bad_d   = 1'b0;
    q_d     = q_q;
`ifndef JK_ARB_FIXED_PRIORITY_EN
    ptr_d   = ptr_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (found_c) begin
          win_d = pick_c;
          gnt_d = '0;
          for (int unsigned i = 0; i < NREQ; i++) begin
            if (pick_c == IDW'(i)) begin
              cmd_d    = cmd[2*i +: 2];
              idx_d    = idx[IDXW*i +: IDXW];
              gnt_d[i] = 1'b1;
            end
          end
          state_d = S_GRANT;
        end
      end
      S_GRANT: begin
        // Out-of-range index matches no bit, so the bank is left untouched.
        for (int unsigned b = 0; b < WIDTH; b++) begin
          if (32'(idx_q) == b) begin
            case (cmd_q)
              2'b10:   q_d[b] = 1'b1;
              2'b01:   q_d[b] = 1'b0;
              2'b11:   q_d[b] = ~q_q[b];
              default: q_d[b] = q_q[b];
            endcase
          end
        end
        bad_d = (32'(idx_q) >= WIDTH);
        gnt_d = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
          ack_d[i] = (win_q == IDW'(i));
        end
        state_d = S_APPLY;
      end
      S_APPLY: begin
`ifndef JK_ARB_FIXED_PRIORITY_EN
        ptr_d = (32'(win_q) == NREQ - 1) ? '0 : win_q + IDW'(1);
`endif
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      win_q   <= '0;
      cmd_q   <= '0;
      idx_q   <= '0;
      gnt_q   <= '0;
      ack_q   <= '0;
      busy_q  <= 1'b0;
      bad_q   <= 1'b0;
      q_q     <= '0;
`ifndef JK_ARB_FIXED_PRIORITY_EN
      ptr_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      win_q   <= win_d;
      cmd_q   <= cmd_d;
      idx_q   <= idx_d;
      gnt_q   <= gnt_d;
      ack_q   <= ack_d;
      busy_q  <= busy_d;
      bad_q   <= bad_d;
      q_q     <= q_d;
`ifndef JK_ARB_FIXED_PRIORITY_EN
      ptr_q   <= ptr_d;
`endif
    end
  end

  assign gnt     = gnt_q;
  assign ack     = ack_q;
  assign busy    = busy_q;
  assign bad_idx = bad_q;
  assign q       = q_q;

endmodule

// File: tb/tb_jk_bank_arbiter.sv
// Bench for jk_bank_arbiter: directed scenarios plus randomized traffic against a transaction-level model.
// Expected grant order follows JK_ARB_FIXED_PRIORITY_EN when it is defined.
module tb_jk_bank_arbiter;

  localparam int NREQ  = 4;
  localparam int WIDTH = 8;
  localparam int IDXW  = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req;
  logic [7:0]  cmd;
  logic [11:0] idx;
  logic [3:0]  gnt, ack;
  logic        busy, bad_idx;
  logic [7:0]  q;

  logic [3:0]  req6;
  logic [7:0]  cmd6;
  logic [11:0] idx6;
  logic [3:0]  gnt6, ack6;
  logic        busy6, bad6;
  logic [5:0]  q6;

  always #5 clk = ~clk;

  jk_bank_arbiter #(.NREQ(4), .WIDTH(8), .IDXW(3)) u_dut (
    .clk(clk), .rst(rst), .req(req), .cmd(cmd), .idx(idx),
    .gnt(gnt), .ack(ack), .busy(busy), .q(q), .bad_idx(bad_idx)
  );

  jk_bank_arbiter #(.NREQ(4), .WIDTH(6), .IDXW(3)) u_dut6 (
    .clk(clk), .rst(rst), .req(req6), .cmd(cmd6), .idx(idx6),
    .gnt(gnt6), .ack(ack6), .busy(busy6), .q(q6), .bad_idx(bad6)
  );

  int checks = 0;
  int errors = 0;

  // Transaction-level model: arbitration allowed every 3rd edge, effect lands one edge after grant.
  logic [7:0] m_q;
  logic [3:0] m_gnt, m_ack;
  logic       m_busy, m_bad;
  logic [1:0] m_cmd;
  int         m_ptr, m_win, m_idx, m_apply, m_next, edge_no;

  function automatic void model_reset();
    m_q = '0; m_gnt = '0; m_ack = '0; m_busy = 1'b0; m_bad = 1'b0;
    m_ptr = 0; m_win = 0; m_idx = 0; m_cmd = '0;
    m_apply = -10; m_next = 0;
  endfunction

  function automatic void model_edge(input logic [3:0] r, input logic [7:0] c, input logic [11:0] x);
    int w;
    int base;
    edge_no++;
    m_ack = '0;
    m_bad = 1'b0;
    if (edge_no == m_apply) begin
      if (m_idx < WIDTH) begin
        case (m_cmd)
          2'b10:   m_q[m_idx] = 1'b1;
          2'b01:   m_q[m_idx] = 1'b0;
          2'b11:   m_q[m_idx] = ~m_q[m_idx];
          default: ;
        endcase
      end else begin
        m_bad = 1'b1;
      end
      m_ack[m_win] = 1'b1;
      m_gnt = '0;
    end else if (edge_no == m_apply + 1) begin
      m_busy = 1'b0;
    end else if (edge_no >= m_next && r != 4'b0000) begin
`ifdef JK_ARB_FIXED_PRIORITY_EN
      base = 0;
`else
      base = m_ptr;
`endif
      w = -1;
      for (int k = 0; k < NREQ; k++)
        if (w < 0 && r[(base + k) % NREQ]) w = (base + k) % NREQ;
      m_win = w;
      m_cmd = c[2*w +: 2];
      m_idx = int'(x[IDXW*w +: IDXW]);
      m_gnt = '0;
      m_gnt[w] = 1'b1;
      m_busy = 1'b1;
      m_apply = edge_no + 1;
      m_next = edge_no + 3;
      m_ptr = (w + 1) % NREQ;
    end
  endfunction

  // Advance one clock from a falling edge to the next, keeping the model in step.
  task automatic step();
    logic [3:0]  r;
    logic [7:0]  c;
    logic [11:0] x;
    r = req; c = cmd; x = idx;
    @(posedge clk);
    if (!rst) model_reset();
    else      model_edge(r, c, x);
    @(negedge clk);
  endtask

  task automatic apply_reset();
    rst = 1'b0;
    req = '0; cmd = '0; idx = '0;
    req6 = '0; cmd6 = '0; idx6 = '0;
    model_reset();
    step();
    step();
    rst = 1'b1;
  endtask

  task automatic test_reset();
    #2 rst = 1'b0;
    #1;
    checks++;
    if ({q, gnt, ack, busy, bad_idx} !== 18'h0) begin
      errors++;
      $display("FAIL reset_async: q=%h gnt=%b ack=%b busy=%b bad=%b expected all zero", q, gnt, ack, busy, bad_idx);
    end
    checks++;
    if ({q6, gnt6, ack6, busy6, bad6} !== 16'h0) begin
      errors++;
      $display("FAIL reset_async_w6: q=%h gnt=%b ack=%b busy=%b bad=%b expected all zero", q6, gnt6, ack6, busy6, bad6);
    end
    @(negedge clk);
    step();
    step();
    checks++;
    if ({q, gnt, ack, busy, bad_idx} !== 18'h0) begin
      errors++;
      $display("FAIL reset_held: q=%h gnt=%b ack=%b busy=%b expected all zero", q, gnt, ack, busy);
    end
    rst = 1'b1;
  endtask

  task automatic test_idle();
    for (int c = 0; c < 10; c++) begin
      step();
      checks++;
      if ({q, gnt, ack, busy, bad_idx} !== 18'h0) begin
        errors++;
        $display("FAIL idle cycle %0d: q=%h gnt=%b ack=%b busy=%b expected 00/0000/0000/0", c, q, gnt, ack, busy);
      end
    end
  endtask

  task automatic test_round_robin();
    int         exp_w[5];
    logic [3:0] e;
    logic [7:0] exp_q;
`ifdef JK_ARB_FIXED_PRIORITY_EN
    exp_w = '{0, 0, 0, 0, 0};
    exp_q = 8'h00;
`else
    exp_w = '{0, 1, 2, 3, 0};
    exp_q = 8'h0F;
`endif
    apply_reset();
    req = 4'hF;
    cmd = 8'hFF;
    idx = {3'd3, 3'd2, 3'd1, 3'd0};
    for (int s = 0; s < 15; s++) begin
      step();
      e = '0;
      e[exp_w[s/3]] = 1'b1;
      if (s % 3 == 0) begin
        checks++;
        if (gnt !== e) begin
          errors++;
          $display("FAIL rr_gnt grant %0d: gnt=%b expected %b", s/3, gnt, e);
        end
      end else if (s % 3 == 1) begin
        checks++;
        if ({ack, gnt} !== {e, 4'b0000}) begin
          errors++;
          $display("FAIL rr_ack grant %0d: ack=%b gnt=%b expected ack=%b gnt=0000", s/3, ack, gnt, e);
        end
      end
      if (s == 10) begin
        checks++;
        if (q !== exp_q) begin
          errors++;
          $display("FAIL rr_q: q=%h expected %h", q, exp_q);
        end
      end
    end
    req = '0;
    step();
  endtask

  task automatic test_single();
    logic [1:0] tc[5];
    logic [7:0] tq[5];
    tc = '{2'b10, 2'b01, 2'b11, 2'b11, 2'b00};
    tq = '{8'h08, 8'h00, 8'h08, 8'h00, 8'h00};
    apply_reset();
    for (int t = 0; t < 5; t++) begin
      req = 4'b0001;
      cmd[1:0] = tc[t];
      idx[2:0] = 3'd3;
      step();
      checks++;
      if ({gnt, busy, q} !== {4'b0001, 1'b1, (t == 0) ? 8'h00 : tq[t-1]}) begin
        errors++;
        $display("FAIL single_gnt cmd %0d: gnt=%b busy=%b q=%h expected 0001/1/old q", t, gnt, busy, q);
      end
      step();
      checks++;
      if ({q, ack, gnt, busy} !== {tq[t], 4'b0001, 4'b0000, 1'b1}) begin
        errors++;
        $display("FAIL single_apply cmd %0d: q=%h ack=%b gnt=%b busy=%b expected %h/0001/0000/1", t, q, ack, gnt, busy, tq[t]);
      end
      req = '0;
      step();
      checks++;
      if ({busy, ack, gnt} !== 9'h0) begin
        errors++;
        $display("FAIL single_idle cmd %0d: busy=%b ack=%b gnt=%b expected 0", t, busy, ack, gnt);
      end
    end
  endtask

  task automatic test_latch();
    apply_reset();
    req = 4'b0100;
    cmd[5:4] = 2'b10;
    idx[8:6] = 3'd5;
    step();
    checks++;
    if (gnt !== 4'b0100) begin
      errors++;
      $display("FAIL latch_gnt: gnt=%b expected 0100", gnt);
    end
    req = '0;
    cmd[5:4] = 2'b01;
    idx[8:6] = 3'd1;
    step();
    checks++;
    if ({q, ack} !== {8'h20, 4'b0100}) begin
      errors++;
      $display("FAIL latch_apply: q=%h ack=%b expected 20/0100", q, ack);
    end
    step();
    step();
    step();
    checks++;
    if ({gnt, ack, busy, q} !== {9'h0, 8'h20}) begin
      errors++;
      $display("FAIL latch_after: gnt=%b ack=%b busy=%b q=%h expected 0/0/0/20", gnt, ack, busy, q);
    end
  endtask

  task automatic test_bad_idx();
    apply_reset();
    req6 = 4'b0010;
    cmd6[3:2] = 2'b10;
    idx6[5:3] = 3'd7;
    step();
    checks++;
    if ({gnt6, bad6} !== {4'b0010, 1'b0}) begin
      errors++;
      $display("FAIL bad_gnt: gnt=%b bad=%b expected 0010/0", gnt6, bad6);
    end
    step();
    checks++;
    if ({bad6, q6, ack6} !== {1'b1, 6'h00, 4'b0010}) begin
      errors++;
      $display("FAIL bad_pulse: bad=%b q=%h ack=%b expected 1/00/0010", bad6, q6, ack6);
    end
    req6 = '0;
    step();
    checks++;
    if ({bad6, busy6, ack6, q6} !== 12'h0) begin
      errors++;
      $display("FAIL bad_clear: bad=%b busy=%b ack=%b q=%h expected 0", bad6, busy6, ack6, q6);
    end
    req6 = 4'b0010;
    idx6[5:3] = 3'd5;
    step();
    step();
    checks++;
    if ({bad6, q6, ack6} !== {1'b0, 6'h20, 4'b0010}) begin
      errors++;
      $display("FAIL bad_inrange: bad=%b q=%h ack=%b expected 0/20/0010", bad6, q6, ack6);
    end
    req6 = '0;
    step();
  endtask

  task automatic test_reset_mid();
    int bits[4];
    bits = '{0, 2, 4, 6};
    apply_reset();
    for (int b = 0; b < 4; b++) begin
      req = 4'b0100;
      cmd[5:4] = 2'b10;
      idx[8:6] = 3'(bits[b]);
      step();
      step();
      req = '0;
      step();
    end
    checks++;
    if (q !== 8'h55) begin
      errors++;
      $display("FAIL mid_setup: q=%h expected 55", q);
    end
    req = 4'b0100;
    cmd[5:4] = 2'b11;
    idx[8:6] = 3'd1;
    step();
    checks++;
    if ({gnt, q} !== {4'b0100, 8'h55}) begin
      errors++;
      $display("FAIL mid_grant: gnt=%b q=%h expected 0100/55", gnt, q);
    end
    req = 4'b1001;
    cmd[1:0] = 2'b10; idx[2:0] = 3'd7;
    cmd[7:6] = 2'b10; idx[11:9] = 3'd6;
    rst = 1'b0;
    model_reset();
    #1;
    checks++;
    if ({q, gnt, ack, busy} !== 17'h0) begin
      errors++;
      $display("FAIL mid_async: q=%h gnt=%b ack=%b busy=%b expected 0", q, gnt, ack, busy);
    end
    @(negedge clk);
    step();
    checks++;
    if ({q, gnt, ack, busy} !== 17'h0) begin
      errors++;
      $display("FAIL mid_noack: q=%h gnt=%b ack=%b busy=%b expected 0", q, gnt, ack, busy);
    end
    rst = 1'b1;
    step();
    checks++;
    if (gnt !== 4'b0001) begin
      errors++;
      $display("FAIL mid_first: gnt=%b expected 0001", gnt);
    end
    step();
    checks++;
    if ({q, ack} !== {8'h80, 4'b0001}) begin
      errors++;
      $display("FAIL mid_first_apply: q=%h ack=%b expected 80/0001", q, ack);
    end
    req[0] = 1'b0;
    step();
    step();
    checks++;
    if (gnt !== 4'b1000) begin
      errors++;
      $display("FAIL mid_second: gnt=%b expected 1000", gnt);
    end
    step();
    checks++;
    if ({q, ack} !== {8'hC0, 4'b1000}) begin
      errors++;
      $display("FAIL mid_second_apply: q=%h ack=%b expected C0/1000", q, ack);
    end
    req = '0;
    step();
  endtask

  task automatic test_random();
    apply_reset();
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (m_ack[i]) begin
          if ($urandom_range(0, 3) != 0) req[i] = 1'b0;
        end else if (m_gnt[i]) begin
          cmd[2*i +: 2] = 2'($urandom);
          idx[IDXW*i +: IDXW] = 3'($urandom);
          if ($urandom_range(0, 3) == 0) req[i] = 1'b0;
        end else if (!req[i] && $urandom_range(0, 2) == 0) begin
          req[i] = 1'b1;
          cmd[2*i +: 2] = 2'($urandom);
          idx[IDXW*i +: IDXW] = 3'($urandom);
        end
      end
      step();
      checks++;
      if ({q, gnt, ack, busy, bad_idx} !== {m_q, m_gnt, m_ack, m_busy, m_bad}) begin
        errors++;
        $display("FAIL random cycle %0d: q=%h gnt=%b ack=%b busy=%b bad=%b expected q=%h gnt=%b ack=%b busy=%b bad=%b",
                 c, q, gnt, ack, busy, bad_idx, m_q, m_gnt, m_ack, m_busy, m_bad);
      end
    end
    req = '0;
    step();
  endtask

  initial begin
    rst = 1'b1;
    req = '0; cmd = '0; idx = '0;
    req6 = '0; cmd6 = '0; idx6 = '0;
    edge_no = 0;
    model_reset();
    test_reset();
    test_idle();
    test_round_robin();
    test_single();
    test_latch();
    test_bad_idx();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/jk_bank_arbiter.md
Name: jk_bank_arbiter

Overview:
- Shares one bank of WIDTH JK flip-flops between NREQ requesters.
- Each requester posts a JK command (hold/set/reset/toggle) aimed at one bit of the bank.
- Round-robin arbitration picks one requester, latches its command, applies it to the addressed bit and acknowledges.
- Sits above the JK flip-flop datapath as its sequencer and access controller.

Parameters:
- NREQ, 4, number of requesters (2..8).
- WIDTH, 8, number of JK bits in the bank.
- IDXW, 3, bit-index width; must satisfy 2**IDXW >= WIDTH.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous reset, active-low; asserts immediately, deasserts synchronously to clk.
- req  input  NREQ  request per requester; level, held high until ack.
- cmd  input  2*NREQ  per-requester {J,K}; requester i uses bits [2i+1:2i], J = bit 2i+1.
- idx  input  NREQ*IDXW  per-requester target bit; requester i uses bits [IDXW*i+IDXW-1:IDXW*i].
- gnt  output  NREQ  one-hot grant, registered.
- ack  output  NREQ  one-cycle completion pulse to the granted requester.
- busy  output  1  high whenever the FSM is not IDLE.
- q  output  WIDTH  JK bank state.
- bad_idx  output  1  one-cycle pulse when the latched idx >= WIDTH.

Behaviour:
- Reset (rst=0):
  - q, gnt, ack, busy and bad_idx go to 0; FSM goes to IDLE.
  - Round-robin pointer goes to 0, so requester 0 has highest priority after reset.
  - Any in-flight command is discarded with no ack.
- FSM states: IDLE -> GRANT -> APPLY -> IDLE.
- IDLE:
  - If req is all-zero, stay in IDLE.
  - Otherwise pick the winner: the first requester with req=1, searching from ptr upward and wrapping NREQ-1 -> 0.
  - Latch the winner id plus its cmd and idx; set gnt[winner]=1; go to GRANT.
- GRANT:
  - Update q[latched idx]: {J,K}=00 holds, 10 sets to 1, 01 resets to 0, 11 inverts.
  - If latched idx >= WIDTH, q is unchanged and bad_idx pulses high this cycle.
  - Go to APPLY.
- APPLY:
  - ack[winner]=1 for exactly this cycle; gnt goes to 0 on entry to APPLY.
  - ptr = (winner+1) mod NREQ; go to IDLE.
- Timing:
  - Latency: a req seen in IDLE at edge N gives gnt after edge N, the q update after edge N+1, and ack high after edge N+1 for one cycle.
  - Peak throughput: one command every 3 cycles.
- Only values latched at grant are used. Changing or dropping req/cmd/idx after grant has no effect on the command in flight.
- A requester holding req high across ack is re-arbitrated in the next IDLE, behind all other pending requesters.
- At most one gnt bit and at most one ack bit are ever high.
- q bits not addressed never change.
- A single active requester with WIDTH=8 can toggle each bit at most once per 3 cycles.

Optional Feature:
- Macro: JK_ARB_FIXED_PRIORITY_EN.
- Defined: fixed priority replaces round-robin. The lowest-numbered active requester always wins; ptr is not used or updated.
- Undefined (default): round-robin as specified above.
- Ports, latency and all other behaviour are identical in both builds.

Test Plan:
- Reset, then no req for 10 cycles -> q=8'h00, gnt=0, ack=0, busy=0 throughout.
- Requester 0 issues cmd=10 (set), idx=3 -> gnt=4'b0001 one cycle after req, q=8'h08 the next cycle, ack[0] pulses, busy drops; then cmd=01, idx=3 -> q=8'h00; then cmd=11, idx=3 twice -> q=8'h08 then q=8'h00; then cmd=00 -> q unchanged.
- All four requesters hold req continuously, each with cmd=11 on its own idx=i:
  - Round-robin build: grant order 0,1,2,3,0.
  - JK_ARB_FIXED_PRIORITY_EN build: requester 0 wins every time.
  - After 4 commands (round-robin) q=8'h0F.
- Requester 2 drops req and changes cmd/idx in the cycle after gnt -> the latched command still executes; ack[2] still pulses.
- WIDTH=6, IDXW=3, requester 1 sends idx=7, cmd=10 -> bad_idx pulses one cycle, q unchanged, ack[1] still pulses.
- rst driven low during GRANT with q=8'h55 -> q=8'h00, gnt=0 immediately (asynchronous), no ack. After release, requester 0 wins first even with requesters 0 and 3 both pending.
